adc_capture: RTL

Parametrised receive ingest stage between the AD936x-style ADC sample ports and the receive DSP chain (synchronization onward). Captures I/Q samples from one selected channel or from all channels round-robin, buffers them in a FIFO and emits them as a ready/valid stream framed with `m_last` every `FRAME_LEN` samples. It replaces the fixed channel-0, unbuffered ADC hookup and adds backpressure absorption, framing, overflow accounting and a frame-done interrupt.

---
 rtl/wiphy_pkg.sv | 22 ++
 rtl/sample_fifo.sv | 61 ++++++
 rtl/adc_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/wiphy_pkg.sv
// Shared receive-path types: the default-width I/Q sample, the capture FSM states
// and an index-width helper that never returns zero bits.
package wiphy_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] q;
    logic [SAMPLE_W-1:0] i;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } capture_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// DEPTH-entry FIFO with a registered head; a written word is presented one cycle later.
// Writes are accepted when not full, or when the head is popped in the same cycle.
module sample_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         wr_ok_o,
  input  logic         rd_rdy_i,
  output logic         rd_vld_o,
  output logic [W-1:0] rd_dat_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          vld_q;
  logic [W-1:0]  dat_q;
  logic          pop, push;

  assign pop     = vld_q && rd_rdy_i;
  assign wr_ok_o = (cnt_q != (AW+1)'(DEPTH)) || pop;
  assign push    = wr_en_i && wr_ok_o;
  assign empty_o = (cnt_q == '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // The head register only ever loads entries written on an earlier edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= (cnt_q - (AW+1)'(pop)) != '0;
      if (!vld_q || pop) dat_q <= mem_q[rd_ptr_d];
    end
  end

  assign rd_vld_o = vld_q;
  assign rd_dat_o = dat_q;

endmodule

// File: rtl/adc_capture.sv
// ADC I/Q capture (single channel or round-robin) into a FIFO, framed ready/valid output; 2-cycle latency.
// Full FIFO drops samples; ADC_CAPTURE_OVERFLOW_EN adds the saturating drop counter.
module adc_capture
  import wiphy_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [CHANNELS-1:0]             adc_valid,
  input  logic [CHANNELS*2*WIDTH-1:0]     adc_data,
  input  logic                            enable,
  input  logic                            interleave,
  input  logic [idx_w(CHANNELS)-1:0]      chan_sel,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [2*WIDTH-1:0]              m_data,
  output logic [idx_w(CHANNELS)-1:0]      m_user,
  output logic                            m_last,
  output logic [15:0]                     overflow,
  output logic                            busy,
  output logic                            irq
);

  localparam int UW = idx_w(CHANNELS);
  localparam int SW = 2 * WIDTH;
  localparam int FW = SW + UW;
  localparam int CW = $clog2(FRAME_LEN);

  capture_state_t            state_q;
  logic                      ilv_q;
  logic [UW-1:0]             sel_q;
  logic [CHANNELS*SW-1:0]    cap_q;
  logic                      ser_busy_q;
  logic [UW-1:0]             ser_idx_q;
  logic [CW-1:0]             fcnt_q;
  logic                      irq_q;

  logic                      run, cap_hit;
  logic                      wr_en, fifo_wr_ok, fifo_empty, fifo_vld;
  logic [FW-1:0]             wr_dat, fifo_dat;

  assign run     = (state_q == RUN);
  assign cap_hit = run && ilv_q && adc_valid[0] && !ser_busy_q;

  // Channel 0 of a capture goes straight to the FIFO; the rest follow from cap_q.
  always_comb begin
    wr_en  = 1'b0;
    wr_dat = '0;
    if (ser_busy_q) begin
      wr_en  = 1'b1;
      wr_dat = {ser_idx_q, cap_q[ser_idx_q*SW +: SW]};
    end else if (cap_hit) begin
      wr_en  = 1'b1;
      wr_dat = {UW'(0), adc_data[SW-1:0]};
    end else if (run && !ilv_q && adc_valid[sel_q]) begin
      wr_en  = 1'b1;
      wr_dat = {sel_q, adc_data[sel_q*SW +: SW]};
    end
  end

  sample_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .aresetn  (aresetn),
    .wr_en_i  (wr_en),
    .wr_dat_i (wr_dat),
    .wr_ok_o  (fifo_wr_ok),
    .rd_rdy_i (m_ready),
    .rd_vld_o (fifo_vld),
    .rd_dat_o (fifo_dat),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      ilv_q      <= 1'b0;
      sel_q      <= '0;
      cap_q      <= '0;
      ser_busy_q <= 1'b0;
      ser_idx_q  <= '0;
      fcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= m_valid && m_ready && m_last;
      if (m_valid && m_ready)
        fcnt_q <= (fcnt_q == CW'(FRAME_LEN-1)) ? '0 : fcnt_q + CW'(1);
      if (cap_hit) begin
        cap_q      <= adc_data;
        ser_busy_q <= (CHANNELS > 1);
        ser_idx_q  <= UW'(1);
      end else if (ser_busy_q) begin
        ser_idx_q <= ser_idx_q + UW'(1);
        if (ser_idx_q == UW'(CHANNELS-1)) ser_busy_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          ilv_q <= interleave;
          sel_q <= chan_sel;
          if (enable) state_q <= RUN;
        end
        RUN:   if (!enable) state_q <= DRAIN;
        // Leave only on a frame boundary so the next run starts a fresh frame.
        DRAIN: begin
          if (enable) state_q <= RUN;
          else if (!ser_busy_q && fifo_empty && fcnt_q == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADC_CAPTURE_OVERFLOW_EN
  logic        cap_drop;
  logic [15:0] ovf_q;
  logic [16:0] ovf_sum;

  assign cap_drop = run && ilv_q && adc_valid[0] && ser_busy_q;

  always_comb begin
    ovf_sum = {1'b0, ovf_q} + 17'(wr_en && !fifo_wr_ok) + (cap_drop ? 17'(CHANNELS) : 17'd0);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                       ovf_q <= '0;
    else if (state_q == IDLE && enable) ovf_q <= '0;
    else if (ovf_sum[16])               ovf_q <= 16'hFFFF;
    else                                ovf_q <= ovf_sum[15:0];
  end

  assign overflow = ovf_q;
`else
  logic unused_wr_ok;
  assign unused_wr_ok = fifo_wr_ok;
  assign overflow     = '0;
`endif

  assign m_valid = fifo_vld;
  assign m_data  = fifo_dat[SW-1:0];
  assign m_user  = fifo_dat[FW-1:SW];
  assign m_last  = fifo_vld && (fcnt_q == CW'(FRAME_LEN-1));
  assign busy    = (state_q != IDLE);
  assign irq     = irq_q;

endmodule
